// File: rtl/cam2_fill_ctrl.sv
// cam2_fill_ctrl: sole writer of the cam2 tag/data CAM.
// Accepts insert / invalidate / flush / no-op requests, probes the CAM for
// duplicate tags, picks a victim slot (lowest free entry, else round-robin),
// drives the CAM's active-low write port and tracks a shadow valid bitmap.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | ready for a request; no-op requests answered from here
// LOOKUP | captured tag on check_tag; CAM hit/miss sampled at exit edge
// WRITE  | single CAM write cycle (insert victim or invalidate target)
// FLUSH  | WORDS back-to-back invalidating writes, entry flush_cnt each
module cam2_fill_ctrl #(
  parameter int WORDS     = 8,
  parameter int BITS      = 8,
  parameter int ADDR_LEFT = $clog2(WORDS) - 1,
  parameter int TAG_SZ    = 8
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [TAG_SZ-1:0]    req_tag,
  input  logic [BITS-1:0]      req_data,
  input  logic [ADDR_LEFT:0]   req_addr,
  output logic [TAG_SZ-1:0]    check_tag,
  input  logic                 found_it,
  output logic                 write_,
  output logic [ADDR_LEFT:0]   w_addr,
  output logic [BITS-1:0]      wdata,
  output logic [TAG_SZ-1:0]    new_tag,
  output logic                 new_valid,
  output logic                 full,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic [ADDR_LEFT:0]   resp_addr,
  output logic                 resp_evict
);

  localparam int ADDR_W = ADDR_LEFT + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  localparam logic [1:0] OP_INSERT = 2'b00;
  localparam logic [1:0] OP_INVAL  = 2'b01;
  localparam logic [1:0] OP_FLUSH  = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOOKUP = 2'b01,
    WRITE  = 2'b10,
    FLUSH  = 2'b11
  } state_t;

  state_t              state;
  logic [1:0]          op_q;
  logic [TAG_SZ-1:0]   tag_q;
  logic [BITS-1:0]     data_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   victim_q;
  logic                evict_q;
  logic [WORDS-1:0]    valid_q;
  logic [ADDR_W-1:0]   rr_ptr;
  logic [ADDR_W-1:0]   flush_cnt;

  logic                free_found;
  logic [ADDR_W-1:0]   free_idx;
  logic [ADDR_W-1:0]   victim_sel;
  logic [ADDR_W-1:0]   rr_next;

  // The lookup tag is simply the captured tag; it never follows req_tag directly.
  assign check_tag = tag_q;

  // Full when every shadow entry is valid.
  assign full = &valid_q;

  // Lowest-index free entry; scanning downward leaves the smallest index last.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = ADDR_W'(i);
      end
    end
  end

  // Victim choice and round-robin successor (wraps after the last entry).
  always_comb begin
    victim_sel = free_found ? free_idx : rr_ptr;
    rr_next    = (rr_ptr == LAST_ADDR) ? '0 : rr_ptr + 1'b1;
  end

  // Controller FSM with registered CAM-side and response outputs.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state      <= IDLE;
      op_q       <= '0;
      tag_q      <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      victim_q   <= '0;
      evict_q    <= 1'b0;
      valid_q    <= '0;
      rr_ptr     <= '0;
      flush_cnt  <= '0;
      req_ready  <= 1'b1;
      write_     <= 1'b1;
      w_addr     <= '0;
      wdata      <= '0;
      new_tag    <= '0;
      new_valid  <= 1'b0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_addr  <= '0;
      resp_evict <= 1'b0;
    end else begin
      // Responses are single-cycle pulses and read as zero otherwise.
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_addr  <= '0;
      resp_evict <= 1'b0;

      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_q   <= req_op;
            tag_q  <= req_tag;
            data_q <= req_data;
            addr_q <= req_addr;
            case (req_op)
              OP_INSERT: begin
                state     <= LOOKUP;
                req_ready <= 1'b0;
              end
              OP_INVAL: begin
                // Write port is set up now so the write happens in the next cycle.
                state     <= WRITE;
                req_ready <= 1'b0;
                evict_q   <= 1'b0;
                write_    <= 1'b0;
                w_addr    <= req_addr;
                wdata     <= '0;
                new_tag   <= '0;
                new_valid <= 1'b0;
              end
              OP_FLUSH: begin
                state     <= FLUSH;
                req_ready <= 1'b0;
                flush_cnt <= '0;
                write_    <= 1'b0;
                w_addr    <= '0;
                wdata     <= '0;
                new_tag   <= '0;
                new_valid <= 1'b0;
              end
              default: begin
                // No-op: acknowledge immediately and stay ready.
                resp_valid <= 1'b1;
              end
            endcase
          end
        end

        LOOKUP: begin
          if (found_it) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b1;
            resp_hit   <= 1'b1;
          end else begin
            state     <= WRITE;
            victim_q  <= victim_sel;
            evict_q   <= !free_found;
            write_    <= 1'b0;
            w_addr    <= victim_sel;
            wdata     <= data_q;
            new_tag   <= tag_q;
            new_valid <= 1'b1;
          end
        end

        WRITE: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          write_     <= 1'b1;
          w_addr     <= '0;
          wdata      <= '0;
          new_tag    <= '0;
          new_valid  <= 1'b0;
          resp_valid <= 1'b1;
          if (op_q == OP_INSERT) begin
            valid_q[victim_q] <= 1'b1;
            resp_addr         <= victim_q;
            resp_evict        <= evict_q;
            if (evict_q) begin
              rr_ptr <= rr_next;
            end
          end else begin
            // Invalidating an already-invalid entry is harmless and still acked.
            valid_q[addr_q] <= 1'b0;
            resp_addr       <= addr_q;
          end
        end

        FLUSH: begin
          if (flush_cnt == LAST_ADDR) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            flush_cnt  <= '0;
            write_     <= 1'b1;
            w_addr     <= '0;
            valid_q    <= '0;
            rr_ptr     <= '0;
            resp_valid <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
            w_addr    <= flush_cnt + 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          write_    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam2_fill_ctrl.sv
// Bench for cam2_fill_ctrl: behavioural CAM on the write port, a reference
// allocation model feeding an expected-response queue, and per-feature tasks.
module tb_cam2_fill_ctrl;

  logic       clk;
  logic       rst_;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_tag;
  logic [7:0] req_data;
  logic [2:0] req_addr;
  logic [7:0] check_tag;
  logic       found_it;
  logic       write_;
  logic [2:0] w_addr;
  logic [7:0] wdata;
  logic [7:0] new_tag;
  logic       new_valid;
  logic       full;
  logic       resp_valid;
  logic       resp_hit;
  logic [2:0] resp_addr;
  logic       resp_evict;

  cam2_fill_ctrl #(.WORDS(8), .BITS(8), .ADDR_LEFT(2), .TAG_SZ(8)) dut (
    .clk(clk), .rst_(rst_),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_tag(req_tag), .req_data(req_data), .req_addr(req_addr),
    .check_tag(check_tag), .found_it(found_it),
    .write_(write_), .w_addr(w_addr), .wdata(wdata), .new_tag(new_tag),
    .new_valid(new_valid), .full(full),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_addr(resp_addr),
    .resp_evict(resp_evict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural CAM: resets with the controller, written on write_ low.
  logic [7:0] cam_v;
  logic [7:0] cam_t [8];

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cam_v <= '0;
      for (int i = 0; i < 8; i++) cam_t[i] <= '0;
    end else if (!write_) begin
      cam_v[w_addr] <= new_valid;
      cam_t[w_addr] <= new_tag;
    end
  end

  always_comb begin
    found_it = 1'b0;
    for (int i = 0; i < 8; i++)
      if (cam_v[i] && cam_t[i] == check_tag) found_it = 1'b1;
  end

  // Reference allocation model.
  logic [7:0] m_valid;
  logic [7:0] m_tag [8];
  int         m_rr;

  typedef struct {
    int         lat;
    logic       hit;
    logic [2:0] addr;
    logic       evict;
    int         nw;
    logic [2:0] wa;
    logic       nv;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp;
  int n_bad;

  // Observations from the last request.
  int         obs_lat;
  logic       obs_hit, obs_evict, obs_nv, obs_seq, obs_full, obs_full0;
  logic [2:0] obs_addr, obs_wa;
  logic [7:0] obs_nt, obs_wd;
  int         obs_nw;

  task automatic model_reset();
    m_valid = '0;
    m_rr    = 0;
    for (int i = 0; i < 8; i++) m_tag[i] = '0;
  endtask

  // Drive one request, then watch the DUT cycle by cycle until resp_valid.
  task automatic send(input logic [1:0] op, input logic [7:0] tag,
                      input logic [7:0] data, input logic [2:0] addr);
    int w;
    obs_lat = -1; obs_nw = 0; obs_seq = 1'b1;
    obs_hit = 1'b0; obs_evict = 1'b0; obs_addr = '0;
    obs_wa = '0; obs_nv = 1'b0; obs_nt = '0; obs_wd = '0;
    obs_full = 1'b0; obs_full0 = 1'b0;
    w = 0;
    while (!req_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    req_valid = 1'b1; req_op = op; req_tag = tag; req_data = data; req_addr = addr;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 2'b11; req_tag = '0; req_data = '0; req_addr = '0;
    for (int k = 0; k < 40; k++) begin
      if (k == 0) obs_full0 = full;
      if (!write_) begin
        if (obs_nw == 0) begin
          obs_wa = w_addr; obs_nv = new_valid; obs_nt = new_tag; obs_wd = wdata;
        end else if (int'(w_addr) != int'(obs_wa) + obs_nw) begin
          obs_seq = 1'b0;
        end
        obs_nw++;
      end
      if (resp_valid) begin
        obs_lat = k; obs_hit = resp_hit; obs_addr = resp_addr;
        obs_evict = resp_evict; obs_full = full;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    n_cmp++; if (write_ !== 1'b1) begin n_bad++; $display("FAIL rst_write_ got=%b exp=1", write_); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL rst_full got=%b exp=0", full); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    n_cmp++; if ({w_addr, wdata, new_tag, new_valid, check_tag} !== '0)
      begin n_bad++; $display("FAIL rst_cam_outs got=%h exp=0", {w_addr, wdata, new_tag, new_valid, check_tag}); end
  endtask

  task automatic test_insert(input logic [7:0] tag, input logic [7:0] data);
    exp_t e;
    int   fr;
    e.hit = 1'b0;
    for (int i = 0; i < 8; i++) if (m_valid[i] && m_tag[i] == tag) e.hit = 1'b1;
    if (e.hit) begin
      e.lat = 1; e.addr = '0; e.evict = 1'b0; e.nw = 0; e.wa = '0; e.nv = 1'b0;
    end else begin
      fr = -1;
      for (int i = 7; i >= 0; i--) if (!m_valid[i]) fr = i;
      if (fr >= 0) begin
        e.addr = 3'(fr); e.evict = 1'b0;
      end else begin
        e.addr = 3'(m_rr); e.evict = 1'b1; m_rr = (m_rr + 1) % 8;
      end
      m_valid[e.addr] = 1'b1; m_tag[e.addr] = tag;
      e.lat = 2; e.nw = 1; e.wa = e.addr; e.nv = 1'b1;
    end
    exp_q.push_back(e);
    send(2'b00, tag, data, 3'd0);
    e = exp_q.pop_front();
    n_cmp++; if (obs_lat !== e.lat) begin n_bad++; $display("FAIL ins_lat tag=%h got=%0d exp=%0d", tag, obs_lat, e.lat); end
    n_cmp++; if (obs_hit !== e.hit) begin n_bad++; $display("FAIL ins_hit tag=%h got=%b exp=%b", tag, obs_hit, e.hit); end
    n_cmp++; if (obs_addr !== e.addr) begin n_bad++; $display("FAIL ins_addr tag=%h got=%0d exp=%0d", tag, obs_addr, e.addr); end
    n_cmp++; if (obs_evict !== e.evict) begin n_bad++; $display("FAIL ins_evict tag=%h got=%b exp=%b", tag, obs_evict, e.evict); end
    n_cmp++; if (obs_nw !== e.nw) begin n_bad++; $display("FAIL ins_nwrites tag=%h got=%0d exp=%0d", tag, obs_nw, e.nw); end
    n_cmp++; if (obs_full !== (&m_valid)) begin n_bad++; $display("FAIL ins_full tag=%h got=%b exp=%b", tag, obs_full, &m_valid); end
    if (e.nw > 0) begin
      n_cmp++; if (obs_wa !== e.wa) begin n_bad++; $display("FAIL ins_w_addr tag=%h got=%0d exp=%0d", tag, obs_wa, e.wa); end
      n_cmp++; if (obs_nv !== 1'b1) begin n_bad++; $display("FAIL ins_new_valid tag=%h got=%b exp=1", tag, obs_nv); end
      n_cmp++; if (obs_nt !== tag) begin n_bad++; $display("FAIL ins_new_tag got=%h exp=%h", obs_nt, tag); end
      n_cmp++; if (obs_wd !== data) begin n_bad++; $display("FAIL ins_wdata tag=%h got=%h exp=%h", tag, obs_wd, data); end
    end
  endtask

  task automatic test_invalidate(input logic [2:0] a);
    exp_t e;
    logic pre_full;
    pre_full = &m_valid;
    m_valid[a] = 1'b0;
    e.lat = 1; e.hit = 1'b0; e.addr = a; e.evict = 1'b0; e.nw = 1; e.wa = a; e.nv = 1'b0;
    exp_q.push_back(e);
    send(2'b01, 8'hEE, 8'hEE, a);
    e = exp_q.pop_front();
    n_cmp++; if (obs_lat !== e.lat) begin n_bad++; $display("FAIL inv_lat a=%0d got=%0d exp=%0d", a, obs_lat, e.lat); end
    n_cmp++; if (obs_addr !== e.addr || obs_hit !== 1'b0 || obs_evict !== 1'b0)
      begin n_bad++; $display("FAIL inv_resp a=%0d got addr=%0d hit=%b ev=%b", a, obs_addr, obs_hit, obs_evict); end
    n_cmp++; if (obs_nw !== 1 || obs_wa !== a || obs_nv !== 1'b0 || obs_nt !== 8'h00 || obs_wd !== 8'h00)
      begin n_bad++; $display("FAIL inv_write a=%0d got n=%0d wa=%0d nv=%b nt=%h wd=%h", a, obs_nw, obs_wa, obs_nv, obs_nt, obs_wd); end
    n_cmp++; if (obs_full0 !== pre_full) begin n_bad++; $display("FAIL inv_full_during got=%b exp=%b", obs_full0, pre_full); end
    n_cmp++; if (obs_full !== 1'b0) begin n_bad++; $display("FAIL inv_full_after got=%b exp=0", obs_full); end
  endtask

  task automatic test_flush();
    exp_t e;
    model_reset();
    e.lat = 8; e.hit = 1'b0; e.addr = '0; e.evict = 1'b0; e.nw = 8; e.wa = '0; e.nv = 1'b0;
    exp_q.push_back(e);
    send(2'b10, 8'h00, 8'h00, 3'd0);
    e = exp_q.pop_front();
    n_cmp++; if (obs_nw !== e.nw) begin n_bad++; $display("FAIL flush_nwrites got=%0d exp=%0d", obs_nw, e.nw); end
    n_cmp++; if (obs_wa !== e.wa || obs_seq !== 1'b1) begin n_bad++; $display("FAIL flush_addr_seq first=%0d seq=%b exp first=0 seq=1", obs_wa, obs_seq); end
    n_cmp++; if (obs_lat !== e.lat) begin n_bad++; $display("FAIL flush_lat got=%0d exp=%0d", obs_lat, e.lat); end
    n_cmp++; if (obs_addr !== e.addr || obs_nv !== e.nv) begin n_bad++; $display("FAIL flush_resp addr=%0d nv=%b exp 0/0", obs_addr, obs_nv); end
    n_cmp++; if (obs_full !== 1'b0) begin n_bad++; $display("FAIL flush_full got=%b exp=0", obs_full); end
  endtask

  task automatic test_noop();
    exp_t e;
    e.lat = 0; e.hit = 1'b0; e.addr = '0; e.evict = 1'b0; e.nw = 0; e.wa = '0; e.nv = 1'b0;
    exp_q.push_back(e);
    send(2'b11, 8'h5A, 8'h5A, 3'd5);
    e = exp_q.pop_front();
    n_cmp++; if (obs_lat !== e.lat) begin n_bad++; $display("FAIL noop_lat got=%0d exp=%0d", obs_lat, e.lat); end
    n_cmp++; if (obs_hit !== 1'b0 || obs_addr !== 3'd0 || obs_nw !== 0)
      begin n_bad++; $display("FAIL noop_resp got hit=%b addr=%0d nw=%0d exp 0/0/0", obs_hit, obs_addr, obs_nw); end
  endtask

  task automatic test_back_to_back();
    test_noop();
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_in_resp got=%b exp=1", req_ready); end
    test_noop();
    test_insert(8'h77, 8'h01);
    test_invalidate(obs_wa);
  endtask

  task automatic test_fill_evict();
    for (int t = 0; t < 8; t++) test_insert(8'h20 + 8'(t), 8'hC0 + 8'(t));
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL fill_full got=%b exp=1", full); end
    test_insert(8'h30, 8'h30);
    n_cmp++; if (obs_addr !== 3'd0 || obs_evict !== 1'b1) begin n_bad++; $display("FAIL evict_first got addr=%0d ev=%b exp 0/1", obs_addr, obs_evict); end
    test_insert(8'h31, 8'h31);
    n_cmp++; if (obs_addr !== 3'd1 || obs_evict !== 1'b1) begin n_bad++; $display("FAIL evict_second got addr=%0d ev=%b exp 1/1", obs_addr, obs_evict); end
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_op = 2'b00; req_tag = 8'h60; req_data = 8'h66; req_addr = '0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 2'b11;
    @(posedge clk); #1;
    n_cmp++; if (write_ !== 1'b0) begin n_bad++; $display("FAIL rmid_in_write got=%b exp=0", write_); end
    rst_ = 1'b0;
    #1;
    n_cmp++; if (write_ !== 1'b1 || req_ready !== 1'b1 || resp_valid !== 1'b0 || full !== 1'b0)
      begin n_bad++; $display("FAIL rmid_abort write_=%b ready=%b resp=%b full=%b exp 1/1/0/0", write_, req_ready, resp_valid, full); end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_no_resp got=%b exp=0", resp_valid); end
    rst_ = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_ = 1'b0; req_valid = 1'b0; req_op = 2'b11;
    req_tag = '0; req_data = '0; req_addr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_ = 1'b1;
    @(posedge clk); #1;

    test_reset();
    test_insert(8'h11, 8'hA5);
    n_cmp++; if (found_it !== 1'b1) begin n_bad++; $display("FAIL cam_has_11 got=%b exp=1", found_it); end
    test_insert(8'h11, 8'h3C);
    test_back_to_back();
    test_invalidate(3'd0);
    test_fill_evict();
    test_invalidate(3'd3);
    test_invalidate(3'd3);
    test_insert(8'h40, 8'h44);
    n_cmp++; if (obs_addr !== 3'd3 || obs_evict !== 1'b0) begin n_bad++; $display("FAIL refill_hole got addr=%0d ev=%b exp 3/0", obs_addr, obs_evict); end
    test_flush();
    for (int t = 0; t < 8; t++) test_insert(8'h20 + 8'(t), 8'h90 + 8'(t));
    test_insert(8'h50, 8'h55);
    n_cmp++; if (obs_addr !== 3'd0 || obs_evict !== 1'b1) begin n_bad++; $display("FAIL rr_after_flush got addr=%0d ev=%b exp 0/1", obs_addr, obs_evict); end
    test_reset_mid();
    test_insert(8'h11, 8'h12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
